// File: rtl/excp_csr_pkg.sv
// excp_csr_pkg: machine trap CSR addresses, bit positions and constants
package excp_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;
  localparam int MSIE_BIT = 3;
  localparam logic [31:0] MISA_VAL = 32'h4000_1100;
endpackage

// File: rtl/excp_csr_mtrap_cnt64.sv
// csr_cnt64: 64-bit CSR counter; a write to one half freezes the other that cycle
module csr_cnt64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        freeze,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  logic [63:0] value_q, value_d;
  always_comb
    value_d = wr_lo ? {value_q[63:32], wdata} :
              wr_hi ? {wdata, value_q[31:0]} :
              (inc & ~freeze) ? value_q + 64'd1 : value_q;
  always_ff @(posedge clk)
    value_q <= rst ? '0 : value_d;
  assign value = value_q;
endmodule

// File: rtl/excp_csr_mtrap.sv
// excp_csr_mtrap: machine-mode trap CSR file (trap/mret commit, CSR access, counters)
module excp_csr_mtrap
  import excp_csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h80,
  parameter int              HART_ID   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmt_status_ena,
  input  logic            cmt_epc_ena,
  input  logic [XLEN-1:0] cmt_epc,
  input  logic            cmt_cause_ena,
  input  logic [XLEN-1:0] cmt_cause,
  input  logic            cmt_badaddr_ena,
  input  logic [XLEN-1:0] cmt_badaddr,
  input  logic            cmt_mret_ena,
  input  logic            cmt_instret,
  input  logic            csr_rd_en,
  input  logic            csr_wr_en,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_ilegl,
  input  logic            ext_irq,
  input  logic            sft_irq,
  input  logic            tmr_irq,
  input  logic            dbg_mode,
  output logic            mret_flush_req,
  output logic [XLEN-1:0] mret_flush_addr,
  output logic [XLEN-1:0] csr_mtvec_r,
  output logic            status_mie_r,
  output logic            meie_r,
  output logic            mtie_r,
  output logic            msie_r
);
  logic mie_q, mie_d, mpie_q, mpie_d, meie_q, mtie_q, msie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, rd_val;
  logic [2:0] mip_q;
  logic [63:0] mcycle, minstret;
  logic known, ro, mret, wr_ok;
  assign mret  = cmt_mret_ena & ~cmt_status_ena;
  assign wr_ok = csr_wr_en & ~csr_ilegl & ~cmt_status_ena;
  always_comb begin
    known  = 1'b1;
    ro     = 1'b0;
    rd_val = '0;
    case (csr_idx)
      CSR_MSTATUS:   rd_val = XLEN'({2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0});
      CSR_MISA:      begin rd_val = XLEN'(MISA_VAL); ro = 1'b1; end
      CSR_MIE:       rd_val = XLEN'({meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0});
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MIP:       begin rd_val = XLEN'({mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0}); ro = 1'b1; end
      CSR_MCYCLE:    rd_val = XLEN'(mcycle[31:0]);
      CSR_MCYCLEH:   rd_val = XLEN'(mcycle[63:32]);
      CSR_MINSTRET:  rd_val = XLEN'(minstret[31:0]);
      CSR_MINSTRETH: rd_val = XLEN'(minstret[63:32]);
      CSR_MHARTID:   begin rd_val = XLEN'(HART_ID); ro = 1'b1; end
      default:       known = 1'b0;
    endcase
  end
  assign csr_ilegl = (csr_rd_en | csr_wr_en) & (~known | (csr_wr_en & ro));
  assign csr_rdata = (csr_rd_en & ~csr_ilegl) ? rd_val : '0;
  // trap > mret > CSR write for mstatus
  always_comb begin
    mie_d  = mie_q;
    mpie_d = mpie_q;
    if (cmt_status_ena) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_ok && csr_idx == CSR_MSTATUS) begin
      mie_d  = csr_wdata[MIE_BIT];
      mpie_d = csr_wdata[MPIE_BIT];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      msie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ~XLEN'(3);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else begin
      mie_q  <= mie_d;
      mpie_q <= mpie_d;
      mip_q  <= {ext_irq, tmr_irq, sft_irq};
      if (wr_ok && csr_idx == CSR_MIE) begin
        meie_q <= csr_wdata[MEIE_BIT];
        mtie_q <= csr_wdata[MTIE_BIT];
        msie_q <= csr_wdata[MSIE_BIT];
      end
      if (wr_ok && csr_idx == CSR_MTVEC) mtvec_q <= csr_wdata & ~XLEN'(3);
      if (wr_ok && csr_idx == CSR_MSCRATCH) mscratch_q <= csr_wdata;
      if (cmt_status_ena & cmt_epc_ena) mepc_q <= cmt_epc & ~XLEN'(1);
      else if (wr_ok && csr_idx == CSR_MEPC) mepc_q <= csr_wdata & ~XLEN'(1);
      if (cmt_status_ena & cmt_cause_ena) mcause_q <= cmt_cause;
      else if (wr_ok && csr_idx == CSR_MCAUSE) mcause_q <= csr_wdata;
      if (cmt_status_ena & cmt_badaddr_ena) mtval_q <= cmt_badaddr;
      else if (wr_ok && csr_idx == CSR_MTVAL) mtval_q <= csr_wdata;
    end
  end
  csr_cnt64 u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1), .freeze(dbg_mode),
    .wr_lo(wr_ok && csr_idx == CSR_MCYCLE), .wr_hi(wr_ok && csr_idx == CSR_MCYCLEH),
    .wdata(csr_wdata[31:0]), .value(mcycle)
  );
  csr_cnt64 u_minstret (
    .clk(clk), .rst(rst), .inc(cmt_instret & ~cmt_status_ena), .freeze(dbg_mode),
    .wr_lo(wr_ok && csr_idx == CSR_MINSTRET), .wr_hi(wr_ok && csr_idx == CSR_MINSTRETH),
    .wdata(csr_wdata[31:0]), .value(minstret)
  );
  assign mret_flush_req  = mret & ~rst;
  assign mret_flush_addr = mepc_q;
  assign csr_mtvec_r     = mtvec_q;
  assign status_mie_r    = mie_q;
  assign meie_r          = meie_q;
  assign mtie_r          = mtie_q;
  assign msie_r          = msie_q;
endmodule
